// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a (possibly wrapping) range of register-file indices,
// reads each register through a combinational debug port and presents the
// captured words one at a time on a valid/ready output stream.
module reg_dump_reader #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic [4:0]  regNo,
  input  logic [31:0] val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] cur_reg;    // index currently being read / held
  logic [4:0] end_reg;    // last index of the range, latched with start
  logic [4:0] regno_reg;  // debug address seen outside SCAN (last one driven)
  logic       skip_cur;
  logic       at_end;
  logic       accept;

  // Register 0 is passed over without a capture when SKIP_ZERO is set.
  assign skip_cur = SKIP_ZERO && (cur_reg == 5'd0);
  assign at_end   = (cur_reg == end_reg);
  assign accept   = out_valid && out_ready;

  // State register; reset wins over start and over the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (skip_cur) begin
          state_next = at_end ? DONE : SCAN;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          state_next = at_end ? DONE : SCAN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: range latch, index advance, word capture and output hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_reg   <= '0;
      end_reg   <= '0;
      regno_reg <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cur_reg <= first_reg;
            end_reg <= last_reg;
          end
        end
        SCAN: begin
          // Remember the address driven this cycle so regNo keeps it later.
          regno_reg <= cur_reg;
          if (skip_cur) begin
            if (!at_end) begin
              cur_reg <= cur_reg + 5'd1;
            end
          end else begin
            // The word is frozen here; later register-file writes cannot
            // disturb what the consumer sees.
            out_data  <= val;
            out_idx   <= cur_reg;
            out_last  <= at_end;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (!at_end) begin
              // 5-bit add wraps 31 -> 0, which gives the wrapping range walk.
              cur_reg <= cur_reg + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs: debug address mux, busy and the completion pulse.
  always_comb begin
    regNo = regno_reg;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      SCAN: begin
        regNo = cur_reg;
        busy  = 1'b1;
      end
      HOLD: begin
        busy = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: two instances (SKIP_ZERO=0 and 1) share the
// stimulus; a range-walk model predicts each instance's word stream.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [31:0] regfile [32];

  logic [4:0]  rn [2];
  logic [31:0] vv [2];
  logic [31:0] od [2];
  logic [4:0]  oi [2];
  logic [1:0]  ov;
  logic [1:0]  ol;
  logic [1:0]  bz;
  logic [1:0]  dn;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  word_t       exp_q [2][$];
  word_t       got_q [2][$];
  bit          active [2];
  int          hs_cyc [2];
  int          done_cyc [2];
  bit          prev_hold [2];
  logic [31:0] prev_data [2];
  logic [4:0]  prev_idx [2];
  logic        prev_last [2];
  word_t       mon_w;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign vv[0] = regfile[rn[0]];
  assign vv[1] = regfile[rn[1]];

  reg_dump_reader #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .regNo(rn[0]), .val(vv[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_idx(oi[0]),
    .out_last(ol[0]), .busy(bz[0]), .done(dn[0])
  );

  reg_dump_reader #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .regNo(rn[1]), .val(vv[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_idx(oi[1]),
    .out_last(ol[1]), .busy(bz[1]), .done(dn[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: number of words a dump of f..l (wrapping) must produce.
  function automatic int model_count(input logic [4:0] f, input logic [4:0] l, input bit skip);
    int n = 0;
    logic [4:0] i = f;
    for (int k = 0; k < 32; k++) begin
      if (!(skip && i == 5'd0)) n++;
      if (i == l) break;
      i = i + 5'd1;
    end
    return n;
  endfunction

  // Model: expected word stream for both instances, from the register snapshot.
  task automatic build_expected(input logic [4:0] f, input logic [4:0] l);
    word_t w;
    for (int d = 0; d < 2; d++) begin
      logic [4:0] i = f;
      exp_q[d].delete();
      got_q[d].delete();
      for (int k = 0; k < 32; k++) begin
        if (!(d == 1 && i == 5'd0)) begin
          w.idx  = i;
          w.data = regfile[i];
          w.last = (i == l);
          exp_q[d].push_back(w);
        end
        if (i == l) break;
        i = i + 5'd1;
      end
    end
  endtask

  function automatic logic [5:0] got_idx(input int d, input int k);
    if (k < got_q[d].size()) return {1'b0, got_q[d][k].idx};
    return 6'h3f;
  endfunction

  function automatic logic [32:0] got_data(input int d, input int k);
    if (k < got_q[d].size()) return {1'b0, got_q[d][k].data};
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [1:0] got_last(input int d, input int k);
    if (k < got_q[d].size()) return {1'b0, got_q[d][k].last};
    return 2'b11;
  endfunction

  // Compare process: protocol rules and word stream, every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold[0] = 1'b0;
      prev_hold[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!active[d]) begin
          check("idle_valid", 64'(ov[d]), 64'd0);
          check("idle_busy", 64'(bz[d]), 64'd0);
          check("idle_done", 64'(dn[d]), 64'd0);
        end else begin
          check("busy_done_excl", 64'(bz[d] && dn[d]), 64'd0);
          if (ov[d]) begin
            check("valid_needs_busy", 64'(bz[d]), 64'd1);
            check("regno_holds_idx", 64'(rn[d]), 64'(oi[d]));
          end
        end
        if (prev_hold[d]) begin
          check("hold_valid", 64'(ov[d]), 64'd1);
          check("hold_data", 64'(od[d]), 64'(prev_data[d]));
          check("hold_idx", 64'(oi[d]), 64'(prev_idx[d]));
          check("hold_last", 64'(ol[d]), 64'(prev_last[d]));
        end
        if (ov[d] && out_ready) begin
          if (exp_q[d].size() == 0) begin
            check("extra_word", 64'(oi[d]), 64'h3f);
          end else begin
            mon_w = exp_q[d].pop_front();
            check("word_idx", 64'(oi[d]), 64'(mon_w.idx));
            check("word_data", 64'(od[d]), 64'(mon_w.data));
            check("word_last", 64'(ol[d]), 64'(mon_w.last));
            mon_w.idx  = oi[d];
            mon_w.data = od[d];
            mon_w.last = ol[d];
            got_q[d].push_back(mon_w);
            hs_cyc[d] = cyc;
          end
        end
        prev_hold[d] = ov[d] && !out_ready;
        prev_data[d] = od[d];
        prev_idx[d]  = oi[d];
        prev_last[d] = ol[d];
        if (dn[d]) begin
          done_cyc[d] = cyc;
          check("done_while_active", 64'(active[d]), 64'd1);
          check("done_words_left", 64'(exp_q[d].size()), 64'd0);
          active[d] = 1'b0;
        end
      end
    end
  end

  task automatic reset_pulse();
    rst_n = 1'b0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    build_expected(f, l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    start_cyc = cyc;
    active[0] = 1'b1;
    active[1] = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    first_reg = 5'($urandom);
    last_reg  = 5'($urandom);
  endtask

  task automatic wait_done(input int ready_pct, input bit noise);
    int n = 0;
    while ((active[0] || active[1]) && n < 1500) begin
      start = 1'b0;
      out_ready = (int'($urandom_range(99)) < ready_pct);
      if (noise && (bz[0] || dn[0]) && (bz[1] || dn[1]) && $urandom_range(2) == 0) begin
        start     = 1'b1;
        first_reg = 5'($urandom);
        last_reg  = 5'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (active[0] || active[1]) begin
      check("dump_timeout", 64'd1, 64'd0);
      reset_pulse();
    end
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct, input bit noise);
    start_dump(f, l);
    wait_done(ready_pct, noise);
    check("word_count0", 64'(got_q[0].size()), 64'(model_count(f, l, 1'b0)));
    check("word_count1", 64'(got_q[1].size()), 64'(model_count(f, l, 1'b1)));
    $display("[TB] dump %0d..%0d ready=%0d%% noise=%0d words=%0d/%0d", f, l, ready_pct, noise,
             got_q[0].size(), got_q[1].size());
  endtask

  initial begin
    int n;
    logic [4:0] f;
    logic [4:0] l;
    int pct;

    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    first_reg = '0;
    last_reg = '0;
    active[0] = 1'b0;
    active[1] = 1'b0;
    prev_hold[0] = 1'b0;
    prev_hold[1] = 1'b0;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;

    // Hand-computed word counts that pin the model.
    check("model_3_5", 64'(model_count(5'd3, 5'd5, 1'b0)), 64'd3);
    check("model_30_1", 64'(model_count(5'd30, 5'd1, 1'b0)), 64'd4);
    check("model_31_1_skip", 64'(model_count(5'd31, 5'd1, 1'b1)), 64'd2);
    check("model_0_0_skip", 64'(model_count(5'd0, 5'd0, 1'b1)), 64'd0);
    check("model_5_4", 64'(model_count(5'd5, 5'd4, 1'b0)), 64'd32);
    check("model_5_4_skip", 64'(model_count(5'd5, 5'd4, 1'b1)), 64'd31);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 64'(ov[d]), 64'd0);
      check("rst_last", 64'(ol[d]), 64'd0);
      check("rst_busy", 64'(bz[d]), 64'd0);
      check("rst_done", 64'(dn[d]), 64'd0);
      check("rst_data", 64'(od[d]), 64'd0);
      check("rst_idx", 64'(oi[d]), 64'd0);
      check("rst_regno", 64'(rn[d]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic three-word dump.
    regfile[3] = 32'hA;
    regfile[4] = 32'hB;
    regfile[5] = 32'hC;
    run_dump(5'd3, 5'd5, 100, 1'b0);
    check("d36_idx0", 64'(got_idx(0, 0)), 64'd3);
    check("d36_data0", 64'(got_data(0, 0)), 64'hA);
    check("d36_data1", 64'(got_data(0, 1)), 64'hB);
    check("d36_data2", 64'(got_data(0, 2)), 64'hC);
    check("d36_last1", 64'(got_last(0, 1)), 64'd0);
    check("d36_last2", 64'(got_last(0, 2)), 64'd1);
    check("d36_done_lat", 64'(done_cyc[0] - hs_cyc[0]), 64'd1);
    check("d36_done_lat_skip", 64'(done_cyc[1] - hs_cyc[1]), 64'd1);

    // Wrapping range.
    run_dump(5'd30, 5'd1, 100, 1'b0);
    check("d37_idx0", 64'(got_idx(0, 0)), 64'd30);
    check("d37_idx1", 64'(got_idx(0, 1)), 64'd31);
    check("d37_idx2", 64'(got_idx(0, 2)), 64'd0);
    check("d37_idx3", 64'(got_idx(0, 3)), 64'd1);
    check("d37_last2", 64'(got_last(0, 2)), 64'd0);
    check("d37_last3", 64'(got_last(0, 3)), 64'd1);

    // Skip-zero cases.
    run_dump(5'd31, 5'd1, 100, 1'b0);
    check("d39_skip_n", 64'(got_q[1].size()), 64'd2);
    check("d39_skip_idx0", 64'(got_idx(1, 0)), 64'd31);
    check("d39_skip_idx1", 64'(got_idx(1, 1)), 64'd1);
    run_dump(5'd0, 5'd0, 100, 1'b0);
    check("d39_zero_only_n", 64'(got_q[1].size()), 64'd0);
    check("d39_zero_only_done", 64'(done_cyc[1] - start_cyc), 64'd2);
    check("d39_noskip_idx", 64'(got_idx(0, 0)), 64'd0);

    // Back-pressure while the captured register is rewritten.
    regfile[12] = 32'h1234_5678;
    regfile[13] = 32'h9ABC_DEF0;
    out_ready = 1'b0;
    start_dump(5'd12, 5'd13);
    n = 0;
    while (!(ov[0] && ov[1]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("d38_hold_reached", 64'(ov), 64'd3);
    repeat (5) begin
      regfile[12] = $urandom;
      @(posedge clk); #1;
    end
    wait_done(100, 1'b0);
    check("d38_data0", 64'(got_data(0, 0)), 64'h1234_5678);
    check("d38_data1", 64'(got_data(1, 0)), 64'h1234_5678);
    check("d38_n", 64'(got_q[0].size()), 64'd2);

    // Reset with the second of four words pending.
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    start_dump(5'd8, 5'd11);
    n = 0;
    while (n < 100) begin
      out_ready = (got_q[0].size() == 0);
      if (ov[0] && oi[0] == 5'd9) break;
      @(posedge clk); #1;
      n++;
    end
    check("d40_second_pending", 64'(oi[0]), 64'd9);
    reset_pulse();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("d40_valid", 64'(ov[d]), 64'd0);
      check("d40_busy", 64'(bz[d]), 64'd0);
      check("d40_done", 64'(dn[d]), 64'd0);
      check("d40_regno", 64'(rn[d]), 64'd0);
    end
    repeat (6) @(posedge clk);
    #1;
    run_dump(5'd8, 5'd11, 100, 1'b0);

    // start noise during busy and in the DONE cycle.
    run_dump(5'd20, 5'd24, 70, 1'b1);
    run_dump(5'd5, 5'd4, 100, 1'b0);

    // Randomized dumps.
    repeat (24) begin
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      f = 5'($urandom);
      l = ($urandom_range(3) == 0) ? f : 5'($urandom);
      case ($urandom_range(2))
        0: pct = 100;
        1: pct = 60;
        default: pct = 30;
      endcase
      run_dump(f, l, pct, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 0; when 1, register 0 is never emitted.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port first_reg  input  5  first register index of the range; sampled with start.
REQ-006 SHALL have port last_reg  input  5  last register index of the range; sampled with start.
REQ-007 SHALL have port regNo  output  5  register-file debug read address.
REQ-008 SHALL have port val  input  32  register-file debug read data, combinational from regNo.
REQ-009 SHALL have port out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port out_data  output  32  captured register value.
REQ-012 SHALL have port out_idx  output  5  index of the captured register.
REQ-013 SHALL have port out_last  output  1  marks the final word of the dump.
REQ-014 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-016 SHALL implement states IDLE, SCAN, HOLD and DONE.
REQ-017 IDLE: on start=1, SHALL latch first_reg into cur, latch last_reg into end, and go to SCAN next cycle.
REQ-018 SCAN: regNo SHALL equal cur.
REQ-019 SCAN: at the clock edge, SHALL register val into out_data and cur into out_idx, set out_valid=1, set out_last=(cur==end), and go to HOLD.
REQ-020 SCAN with SKIP_ZERO=1 and cur==0: SHALL capture nothing and advance as in REQ-023 without entering HOLD.
REQ-021 HOLD: out_valid SHALL stay 1, and out_data/out_idx/out_last SHALL stay stable until out_valid&&out_ready.
REQ-022 On the HOLD handshake: if cur==end, SHALL clear out_valid and go to DONE.
REQ-023 On the HOLD handshake otherwise: SHALL clear out_valid, set cur=cur+1 modulo 32 (31 wraps to 0), and go to SCAN.
REQ-024 Range wrap: end<first SHALL traverse first..31 then 0..end; end==first SHALL emit exactly one word.
REQ-025 Word count SHALL be ((end-first) mod 32)+1, less one if SKIP_ZERO=1 and register 0 lies in the range.
REQ-026 Minimum spacing between words SHALL be 2 cycles (SCAN+HOLD); out_valid SHALL never be high in SCAN.
REQ-027 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE; busy=0 in that IDLE cycle.
REQ-028 busy SHALL equal (state!=IDLE && state!=DONE).
REQ-029 start while not in IDLE SHALL be ignored, including in the DONE cycle.
REQ-030 Captured data SHALL be val at the SCAN edge; register-file writes after that edge SHALL NOT alter out_data.
REQ-031 In IDLE, HOLD and DONE, regNo SHALL hold its last driven value (0 after reset).
REQ-032 SKIP_ZERO=1 with range consisting of register 0 only: SHALL emit no words, with done pulsing 2 cycles after start.

Reset
REQ-033 On rst_n=0 at a clock edge, SHALL enter IDLE and clear out_valid, out_last, busy, done, out_data, out_idx, regNo and cur to 0.
REQ-034 Reset mid-dump SHALL abort the dump, emit no further words, and produce no done pulse.
REQ-035 Reset SHALL take priority over start and over the handshake in the same cycle.

Verification
REQ-036 Dump range first=3, last=5, out_ready=1, regs 3/4/5=0xA/0xB/0xC -> words (3,0xA), (4,0xB), (5,0xC,last); done 1 cycle after third handshake.
REQ-037 Range first=30, last=1 -> out_idx sequence 30,31,0,1; out_last only on idx 1.
REQ-038 out_ready held 0 for 5 cycles in HOLD while reg is rewritten -> out_data stays the original value and stable; word accepted when ready rises.
REQ-039 SKIP_ZERO=1, first=31, last=1 -> idx 31,1 only; SKIP_ZERO=1, first=last=0 -> no words, done pulse.
REQ-040 rst_n=0 in HOLD with second of 4 words pending -> out_valid=0 next cycle, busy=0, no done; a new start dumps normally.
REQ-041 start pulsed during busy and in the DONE cycle -> ignored; word count and range unchanged.
